// File: rtl/pulse_rate_meter.sv
// pulse_rate_meter: synchronises and debounces a beat pulse, counts beats per window, reports saturated BPM.
module pulse_rate_meter #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int WINDOW_TICKS   = 15000,
  parameter int BPM_SCALE      = 4,
  parameter int BPM_MAX        = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pulse_in,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       beat,
  output logic       no_signal
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int WW = $clog2(WINDOW_TICKS + 1);
  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;
  state_t state_q, state_d;
  logic s1_q, sync_q, deb_q, deb_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dcnt_q, dcnt_d, dbt;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc, bpm_q, bpm_d;
  logic [15:0] prod;
  logic bpm_valid_q, bpm_valid_d, beat_q, beat_d, no_signal_q, no_signal_d;
  logic tick, deb_flip, report;
  always_comb begin
    tick        = presc_q == PW'(TICK_DIV - 1);
    presc_d     = (state_q == IDLE || tick) ? '0 : presc_q + PW'(1);
    dbt         = dcnt_q + DW'(1);
    deb_flip    = sync_q != deb_q && tick && dbt == DW'(DEBOUNCE_TICKS);
    deb_d       = deb_flip ? sync_q : deb_q;
    dcnt_d      = (sync_q == deb_q || deb_flip) ? '0 : tick ? dbt : dcnt_q;
    beat_d      = deb_flip && sync_q && state_q != IDLE;
    cnt_inc     = (beat_q && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    // enable low on the closing tick suppresses the report entirely
    report      = enable && state_q == MEASURE && tick && wcnt_q == WW'(WINDOW_TICKS - 1);
    prod        = 16'(cnt_inc) * 16'(BPM_SCALE);
    state_d     = !enable ? IDLE : state_q == IDLE ? MEASURE : report ? REPORT : MEASURE;
    wcnt_d      = state_q != MEASURE ? '0 : tick ? wcnt_q + WW'(1) : wcnt_q;
    // a beat landing in the REPORT cycle seeds the next window
    cnt_d       = state_q == IDLE ? 8'd0 : state_q == REPORT ? {7'd0, beat_q} : cnt_inc;
    bpm_d       = report ? (prod > 16'(BPM_MAX) ? 8'(BPM_MAX) : prod[7:0]) : bpm_q;
    bpm_valid_d = report;
    no_signal_d = report ? cnt_inc == 8'd0 : beat_q ? 1'b0 : no_signal_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      sync_q      <= 1'b0;
      deb_q       <= 1'b0;
      presc_q     <= '0;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      cnt_q       <= '0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
      beat_q      <= 1'b0;
      no_signal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= pulse_in;
      sync_q      <= s1_q;
      deb_q       <= deb_d;
      presc_q     <= presc_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      cnt_q       <= cnt_d;
      bpm_q       <= bpm_d;
      bpm_valid_q <= bpm_valid_d;
      beat_q      <= beat_d;
      no_signal_q <= no_signal_d;
    end
  end
  assign bpm       = bpm_q;
  assign bpm_valid = bpm_valid_q;
  assign beat      = beat_q;
  assign no_signal = no_signal_q;
endmodule

// File: tb/tb_pulse_rate_meter.sv
// tb_pulse_rate_meter: randomized pulse trains per window, expected beats/BPM from pulse classification.
module tb_pulse_rate_meter;
  localparam int TD = 4, DB = 2, WT = 100, SC = 4, MX = 250, MXS = 30;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, pulse_in = 1'b0;
  logic [7:0] bpm, bpm_s;
  logic bpm_valid, beat, no_signal, bpm_valid_s, beat_s, no_signal_s;
  int checks = 0, failures = 0, beat_total = 0, valid_total = 0;
  always #5 clk = ~clk;
  pulse_rate_meter #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .WINDOW_TICKS(WT), .BPM_SCALE(SC), .BPM_MAX(MX)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .bpm(bpm), .bpm_valid(bpm_valid), .beat(beat), .no_signal(no_signal));
  pulse_rate_meter #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .WINDOW_TICKS(WT), .BPM_SCALE(SC), .BPM_MAX(MXS)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .bpm(bpm_s), .bpm_valid(bpm_valid_s), .beat(beat_s), .no_signal(no_signal_s));
  always @(negedge clk) begin
    if (beat) beat_total++;
    if (bpm_valid) valid_total++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int exp_bpm(input int n, input int mx);
    return (n * SC > mx) ? mx : n * SC;
  endfunction
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // clean pulses span >= 3 ticks high and low; glitches span at most one tick
  task automatic window_pulses(input int nc, input int ng);
    int kinds[$];
    int j, t;
    for (int i = 0; i < nc; i++) kinds.push_back(1);
    for (int i = 0; i < ng; i++) kinds.push_back(0);
    for (int i = kinds.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = kinds[i]; kinds[i] = kinds[j]; kinds[j] = t;
    end
    @(posedge clk); #1 pulse_in = 1'b0;
    hold(3);
    foreach (kinds[i]) begin
      pulse_in = 1'b1;
      hold(kinds[i] != 0 ? int'($urandom_range(16, 12)) : int'($urandom_range(3, 1)));
      pulse_in = 1'b0;
      hold(kinds[i] != 0 ? int'($urandom_range(16, 12)) : int'($urandom_range(8, 4)));
    end
  endtask
  task automatic wait_report(output bit got);
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      got = bpm_valid;
    end
  endtask
  task automatic window_check(input string tag, input int nc, input int ng);
    int base;
    bit got;
    base = beat_total;
    window_pulses(nc, ng);
    wait_report(got);
    chk({tag, "_seen"}, got, 1);
    chk({tag, "_beats"}, beat_total - base, nc);
    chk({tag, "_bpm"}, bpm, exp_bpm(nc, MX));
    chk({tag, "_bpm_sat"}, bpm_s, exp_bpm(nc, MXS));
    chk({tag, "_nosig"}, no_signal, nc == 0);
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, bpm_valid, 0);
  endtask
  initial begin
    bit got;
    int n, vbase, base;
    hold(3);
    @(negedge clk);
    chk("rst_bpm", bpm, 0);
    chk("rst_valid", bpm_valid, 0);
    chk("rst_beat", beat, 0);
    chk("rst_nosig", no_signal, 0);
    @(posedge clk); #1 rst = 1'b0;
    hold(3);
    enable = 1'b1;
    hold(1);
    window_check("clean", 10, 0);
    window_check("glitch", 2, 10);
    for (int r = 0; r < 4; r++)
      window_check("rand", int'($urandom_range(8, 0)), int'($urandom_range(6, 0)));
    window_check("nosig", 0, 0);
    // rising edge at cycle 391 of the window debounces exactly into the REPORT cycle
    repeat (390) @(posedge clk);
    #1 pulse_in = 1'b1;
    wait_report(got);
    chk("bnd_seen", got, 1);
    chk("bnd_beat_in_report", beat, 1);
    chk("bnd_bpm", bpm, 0);
    @(negedge clk);
    chk("bnd_nosig_cleared", no_signal, 0);
    repeat (3) @(posedge clk);
    #1 pulse_in = 1'b0;
    wait_report(got);
    chk("bnd_next_seen", got, 1);
    chk("bnd_next_bpm", bpm, 4);
    @(negedge clk);
    repeat (199) @(posedge clk);
    #1 enable = 1'b0;
    vbase = valid_total;
    hold(600);
    chk("abort_valid", valid_total - vbase, 0);
    chk("abort_bpm_hold", bpm, 4);
    enable = 1'b1;
    repeat (400) @(posedge clk);
    #1 enable = 1'b0;
    hold(20);
    chk("simul_valid", valid_total - vbase, 0);
    chk("simul_bpm_hold", bpm, 4);
    enable = 1'b1;
    hold(1);
    base = beat_total;
    window_pulses(5, 0);
    chk("prerst_beats", beat_total - base, 5);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_bpm", bpm, 0);
    chk("arst_valid", bpm_valid, 0);
    chk("arst_beat", beat, 0);
    chk("arst_nosig", no_signal, 0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = bpm_valid;
    end
    chk("rst_report_seen", got, 1);
    chk("rst_report_latency", n, WT * TD + 1);
    chk("rst_report_bpm", bpm, 0);
    chk("rst_report_nosig", no_signal, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
